// File: rtl/spi_pkg.sv
// Shared types for the SPI frame loader: FSM states, status word and sync depth.
package spi_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    OVERFLOW = 2'd2,
    COMMIT   = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic       err_long;
    logic       err_short;
    logic       err_partial;
    logic [7:0] count;
  } spi_status_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall detect on the synced level.
module spi_input_sync
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_frame_loader.sv
// Oversampled SPI mode-0 slave: assembles a fixed-length frame per ce window,
// double-buffers it and publishes it atomically; status/echo stream on sdo.
module spi_frame_loader
  import spi_pkg::*;
#(
  parameter int unsigned WORD_BITS   = 8,
  parameter int unsigned FRAME_WORDS = 4,
  parameter int unsigned CNT_BITS    = $clog2(FRAME_WORDS + 1)
) (
  input  logic                             HSOSC_clk,
  input  logic                             reset_n,
  input  logic                             sck,
  input  logic                             sdi,
  input  logic                             ce,
  output logic                             sdo,
  output logic [FRAME_WORDS*WORD_BITS-1:0] frame_data,
  output logic                             frame_valid,
  output logic                             err_short,
  output logic                             err_long,
  output logic                             err_partial,
  output logic [7:0]                       frame_count
);

  localparam int unsigned FRAME_BITS = FRAME_WORDS * WORD_BITS;
  localparam int unsigned BC_BITS    = $clog2(WORD_BITS + 1);

  logic sck_rise, sck_fall, ce_rise, ce_fall, sdi_s;
  logic sck_lvl_unused, ce_lvl_unused, sdi_rise_unused, sdi_fall_unused;

  // ce sync resets low so a window already open at reset release raises no fall edge.
  spi_input_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk(HSOSC_clk), .rst_n(reset_n), .d(sck),
    .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_input_sync #(.RESET_VAL(1'b0)) u_sync_ce (
    .clk(HSOSC_clk), .rst_n(reset_n), .d(ce),
    .q(ce_lvl_unused), .rise(ce_rise), .fall(ce_fall)
  );

  spi_input_sync #(.RESET_VAL(1'b0)) u_sync_sdi (
    .clk(HSOSC_clk), .rst_n(reset_n), .d(sdi),
    .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  spi_state_t             state_q, state_d;
  logic [BC_BITS-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_BITS-1:0]    word_cnt_q, word_cnt_d;
  logic [WORD_BITS-2:0]   word_q, word_d;
  logic [FRAME_BITS-1:0]  shadow_q, shadow_d;
  logic [FRAME_BITS-1:0]  frame_data_q, frame_data_d;
  logic                   frame_valid_q, frame_valid_d;
  spi_status_t            status_q, status_d;
  logic [WORD_BITS-1:0]   sdo_sr_q, sdo_sr_d;
  logic [WORD_BITS-1:0]   echo_q, echo_d;
  logic                   echo_pend_q, echo_pend_d;
  logic                   ce_pend_q, ce_pend_d;

  logic [WORD_BITS-1:0]   word_full;
  logic [WORD_BITS-1:0]   stat_word;
  logic                   commit_ok;

  assign word_full = {word_q, sdi_s};
  assign stat_word = {status_q.err_long, status_q.err_short, status_q.err_partial,
                      (WORD_BITS-3)'(status_q.count)};
  assign commit_ok = (state_q == SHIFT) && (word_cnt_q == CNT_BITS'(FRAME_WORDS)) &&
                     (bit_cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    word_d        = word_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    status_d      = status_q;
    sdo_sr_d      = sdo_sr_q;
    echo_d        = echo_q;
    echo_pend_d   = echo_pend_q;
    ce_pend_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ce_fall || ce_pend_q) begin
          state_d              = SHIFT;
          bit_cnt_d            = '0;
          word_cnt_d           = '0;
          status_d.err_long    = 1'b0;
          status_d.err_short   = 1'b0;
          status_d.err_partial = 1'b0;
          sdo_sr_d             = stat_word;
          echo_pend_d          = 1'b0;
        end
      end

      SHIFT, OVERFLOW: begin
        if (ce_rise) begin
          // Publish on the transition so frame_data and frame_valid land together in COMMIT.
          state_d = COMMIT;
          if (commit_ok) begin
            frame_data_d   = shadow_q;
            frame_valid_d  = 1'b1;
            status_d.count = status_q.count + 8'd1;
          end else if (state_q == OVERFLOW) begin
            status_d.err_long = 1'b1;
          end else if (bit_cnt_q != '0) begin
            status_d.err_partial = 1'b1;
          end else begin
            status_d.err_short = 1'b1;
          end
        end else begin
          if (sck_rise && state_q == SHIFT) begin
            if (word_cnt_q == CNT_BITS'(FRAME_WORDS)) begin
              state_d = OVERFLOW;
            end else if (bit_cnt_q == BC_BITS'(WORD_BITS - 1)) begin
              for (int unsigned i = 0; i < FRAME_WORDS; i++) begin
                if (word_cnt_q == CNT_BITS'(i)) begin
                  shadow_d[(FRAME_WORDS-1-i)*WORD_BITS +: WORD_BITS] = word_full;
                end
              end
              word_cnt_d  = word_cnt_q + 1'b1;
              bit_cnt_d   = '0;
              echo_d      = word_full;
              echo_pend_d = 1'b1;
            end else begin
              word_d    = word_full[WORD_BITS-2:0];
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          // The echo is held until the next sck fall so sdo never moves on a rising edge.
          if (sck_fall) begin
            if (echo_pend_q) begin
              sdo_sr_d    = echo_q;
              echo_pend_d = 1'b0;
            end else begin
              sdo_sr_d = {sdo_sr_q[WORD_BITS-2:0], 1'b0};
            end
          end
        end
      end

      COMMIT: begin
        state_d   = IDLE;
        ce_pend_d = ce_fall;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HSOSC_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      word_q        <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      status_q      <= '0;
      sdo_sr_q      <= '0;
      echo_q        <= '0;
      echo_pend_q   <= 1'b0;
      ce_pend_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      word_q        <= word_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      status_q      <= status_d;
      sdo_sr_q      <= sdo_sr_d;
      echo_q        <= echo_d;
      echo_pend_q   <= echo_pend_d;
      ce_pend_q     <= ce_pend_d;
    end
  end

  assign sdo         = sdo_sr_q[WORD_BITS-1];
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign err_long    = status_q.err_long;
  assign err_short   = status_q.err_short;
  assign err_partial = status_q.err_partial;
  assign frame_count = status_q.count;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: frames, sdo status/echo, error windows, reset, back-to-back.
module tb_spi_frame_loader;

  logic        clk;
  logic        reset_n;
  logic        sck;
  logic        sdi;
  logic        ce;
  logic        sdo;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        err_short;
  logic        err_long;
  logic        err_partial;
  logic [7:0]  frame_count;

  int n_tests   = 0;
  int n_fail    = 0;
  int valid_cnt = 0;

  spi_frame_loader #(.WORD_BITS(8), .FRAME_WORDS(4)) dut (
    .HSOSC_clk  (clk),
    .reset_n    (reset_n),
    .sck        (sck),
    .sdi        (sdi),
    .ce         (ce),
    .sdo        (sdo),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .err_short  (err_short),
    .err_long   (err_long),
    .err_partial(err_partial),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) valid_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ce_low();
    ce = 1'b0;
    #60;
  endtask

  // sck = clk/8; sdo sampled just before each rising sck, as a mode-0 master would.
  task automatic send_bits(input logic [63:0] v, input int n, output logic [63:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      sdi = v[63-i];
      #40;
      cap = {cap[62:0], sdo};
      sck = 1'b1;
      #40;
      sck = 1'b0;
    end
  endtask

  task automatic ce_high_wait(output int lat);
    #40;
    ce  = 1'b1;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (frame_valid === 1'b1 && lat == 99) lat = i;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cap;
    int          lat;
    int          v0;

    reset_n = 1'b0; ce = 1'b1; sck = 1'b0; sdi = 1'b0;
    #50;
    check("rst_data",  frame_data, 0);
    check("rst_count", frame_count, 0);
    check("rst_err",   {err_long, err_short, err_partial}, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_sdo",   sdo, 0);
    reset_n = 1'b1;
    #50;

    // Frame 1
    v0 = valid_cnt;
    ce_low();
    send_bits({32'hA53CFF01, 32'h0}, 32, cap);
    ce_high_wait(lat);
    check("f1_pulses", valid_cnt - v0, 1);
    check("f1_latency_ok", lat <= 4, 1);
    check("f1_data",  frame_data, 32'hA53CFF01);
    check("f1_count", frame_count, 1);
    check("f1_err",   {err_long, err_short, err_partial}, 0);
    check("f1_sdo",   cap[31:0], 32'h00A53CFF);

    // Frame 2: status 0x01 then echo
    v0 = valid_cnt;
    ce_low();
    send_bits({32'hA53CFF01, 32'h0}, 32, cap);
    ce_high_wait(lat);
    check("f2_sdo",    cap[31:0], 32'h01A53CFF);
    check("f2_pulses", valid_cnt - v0, 1);
    check("f2_count",  frame_count, 2);

    // Short window: 3 words
    v0 = valid_cnt;
    ce_low();
    send_bits({24'h112233, 40'h0}, 24, cap);
    ce_high_wait(lat);
    check("short_err",    {err_long, err_short, err_partial}, 3'b010);
    check("short_pulses", valid_cnt - v0, 0);
    check("short_data",   frame_data, 32'hA53CFF01);
    check("short_count",  frame_count, 2);

    // Recovery frame; flags clear on ce fall
    v0 = valid_cnt;
    ce_low();
    check("rec_short_cleared", err_short, 0);
    send_bits({32'hDEADBEEF, 32'h0}, 32, cap);
    ce_high_wait(lat);
    check("rec_status", cap[31:24], 8'h42);
    check("rec_data",   frame_data, 32'hDEADBEEF);
    check("rec_count",  frame_count, 3);
    check("rec_pulses", valid_cnt - v0, 1);
    check("rec_err",    {err_long, err_short, err_partial}, 0);

    // 4 words + 3 bits
    v0 = valid_cnt;
    ce_low();
    send_bits(64'h1122334455667788, 35, cap);
    ce_high_wait(lat);
    check("long_err",    {err_long, err_short, err_partial}, 3'b100);
    check("long_pulses", valid_cnt - v0, 0);
    check("long_data",   frame_data, 32'hDEADBEEF);
    check("long_count",  frame_count, 3);

    // 2 words + 5 bits
    v0 = valid_cnt;
    ce_low();
    send_bits(64'h1122334455667788, 21, cap);
    ce_high_wait(lat);
    check("part_status", cap[20:13], 8'h83);
    check("part_err",    {err_long, err_short, err_partial}, 3'b001);
    check("part_pulses", valid_cnt - v0, 0);

    // Window with no sck edges
    v0 = valid_cnt;
    ce_low();
    ce_high_wait(lat);
    check("zero_err",    {err_long, err_short, err_partial}, 3'b010);
    check("zero_pulses", valid_cnt - v0, 0);

    // Reset after 10 bits, then finish the stale window
    v0 = valid_cnt;
    ce_low();
    send_bits({32'hA53CFF01, 32'h0}, 10, cap);
    reset_n = 1'b0;
    #30;
    check("mrst_data",  frame_data, 0);
    check("mrst_count", frame_count, 0);
    check("mrst_err",   {err_long, err_short, err_partial}, 0);
    check("mrst_valid", frame_valid, 0);
    check("mrst_sdo",   sdo, 0);
    #20;
    reset_n = 1'b1;
    #20;
    send_bits({32'hA53CFF01, 32'h0} << 10, 22, cap);
    ce_high_wait(lat);
    check("stale_pulses", valid_cnt - v0, 0);
    check("stale_data",   frame_data, 0);
    check("stale_count",  frame_count, 0);
    check("stale_err",    {err_long, err_short, err_partial}, 0);

    v0 = valid_cnt;
    ce_low();
    send_bits({32'h12345678, 32'h0}, 32, cap);
    ce_high_wait(lat);
    check("post_status", cap[31:24], 8'h00);
    check("post_data",   frame_data, 32'h12345678);
    check("post_count",  frame_count, 1);
    check("post_pulses", valid_cnt - v0, 1);

    // Back-to-back: ce high for one clock, so the fall lands in the COMMIT cycle
    v0 = valid_cnt;
    ce_low();
    send_bits({32'hCAFEBABE, 32'h0}, 32, cap);
    #40;
    ce = 1'b1;
    #10;
    ce = 1'b0;
    #60;
    send_bits({32'h0F1E2D3C, 32'h0}, 32, cap);
    ce_high_wait(lat);
    check("b2b_status", cap[31:24], 8'h02);
    check("b2b_pulses", valid_cnt - v0, 2);
    check("b2b_count",  frame_count, 3);
    check("b2b_data",   frame_data, 32'h0F1E2D3C);
    check("b2b_err",    {err_long, err_short, err_partial}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
